alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_pkg.sv | 33 +++
 rtl/alu_issue_decode.sv | 46 ++++
 rtl/alu_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - opcode, ALU-op and state encodings shared by the issue controller and the ALU
package alu_issue_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_SLTI = 4'd8;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_SLTI = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_WB} state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_SLTI;
  endfunction

  // Only the adder-based instructions are allowed to report overflow.
  function automatic logic op_sets_ovf(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational instruction decode into ALU controls and write target
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int RA = 2
) (
  input  logic [15:0]   instr,
  output logic [2:0]    alu_op,
  output logic          alu_bnegate,
  output logic [3:0]    alu_shamt,
  output logic          use_imm,
  output logic [RA-1:0] waddr,
  output logic          legal
);

  logic [3:0] op;
  logic       unused_bits;

  assign op          = instr[15:12];
  assign unused_bits = ^instr[1:0];

  always_comb begin
    alu_op      = ALU_AND;
    alu_bnegate = 1'b0;
    alu_shamt   = 4'd0;
    use_imm     = 1'b0;
    waddr       = instr[7:6];
    legal       = op_legal(op);
    case (op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  begin alu_op = ALU_ADD; alu_bnegate = 1'b1; end
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_SLT:  begin alu_op = ALU_SLT; alu_bnegate = 1'b1; end
      OP_SLL:  begin alu_op = ALU_SLL; alu_shamt = instr[5:2]; end
      OP_SRA:  begin alu_op = ALU_SRA; alu_shamt = instr[5:2]; end
      // I-type writes back to rt rather than rd
      OP_ADDI: begin alu_op = ALU_ADD; use_imm = 1'b1; waddr = instr[9:8]; end
      OP_SLTI: begin
        alu_op = ALU_SLTI; alu_bnegate = 1'b1; use_imm = 1'b1; waddr = instr[9:8];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - four-state issue FSM: accept, read operands, drive ALU, write back
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DW = 16,
  parameter int RA = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  output logic [RA-1:0] rf_raddr1,
  output logic [RA-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic          rf_we,
  output logic [RA-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  output logic          alu_bnegate,
  output logic [3:0]    alu_shamt,
  input  logic [DW-1:0] alu_rez,
  input  logic          alu_zero,
  input  logic          alu_overflow,
  output logic          done,
  output logic          illegal,
  output logic          zero_flag,
  output logic          ovf_flag
);

  state_e        state;
  logic [15:0]   instr_q;
  logic [DW-1:0] opa_q, opb_q, rez_q;
  logic          rzero_q, rovf_q;

  logic [2:0]    dec_alu_op;
  logic          dec_bnegate, dec_use_imm, dec_legal;
  logic [3:0]    dec_shamt;
  logic [RA-1:0] dec_waddr;
  logic [DW-1:0] imm_sext;

  alu_issue_decode #(.RA(RA)) u_decode (
    .instr       (instr_q),
    .alu_op      (dec_alu_op),
    .alu_bnegate (dec_bnegate),
    .alu_shamt   (dec_shamt),
    .use_imm     (dec_use_imm),
    .waddr       (dec_waddr),
    .legal       (dec_legal)
  );

  assign imm_sext  = {{(DW-8){instr_q[7]}}, instr_q[7:0]};
  assign rf_raddr1 = (state == ST_DECODE) ? instr_q[11:10] : '0;
  assign rf_raddr2 = (state == ST_DECODE) ? instr_q[9:8]   : '0;
  assign rf_waddr  = dec_waddr;
  assign rf_wdata  = rez_q;

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = 3'b000;
    alu_bnegate = 1'b0;
    alu_shamt   = 4'd0;
    if (state == ST_EXEC) begin
      alu_a       = opa_q;
      alu_b       = dec_use_imm ? imm_sext : opb_q;
      alu_op      = dec_alu_op;
      alu_bnegate = dec_bnegate;
      alu_shamt   = dec_shamt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      instr_ready <= 1'b1;
      rf_we       <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      zero_flag   <= 1'b0;
      ovf_flag    <= 1'b0;
      instr_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rez_q       <= '0;
      rzero_q     <= 1'b0;
      rovf_q      <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: if (instr_valid && instr_ready) begin
          instr_q     <= instr;
          // legality is judged on the incoming word so the pulse lands in DECODE
          illegal     <= !op_legal(instr[15:12]);
          instr_ready <= 1'b0;
          state       <= ST_DECODE;
        end
        ST_DECODE: begin
          opa_q <= rf_rdata1;
          opb_q <= rf_rdata2;
          if (dec_legal) begin
            state <= ST_EXEC;
          end else begin
            instr_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rez_q   <= alu_rez;
          rzero_q <= alu_zero;
          rovf_q  <= alu_overflow;
          rf_we   <= 1'b1;
          done    <= 1'b1;
          state   <= ST_WB;
        end
        ST_WB: begin
          zero_flag   <= rzero_q;
          ovf_flag    <= rovf_q && op_sets_ovf(instr_q[15:12]);
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed and random instructions checked against an architectural model
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        instr_ready;
  logic [1:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;
  logic [15:0] alu_a, alu_b, alu_rez;
  logic [2:0]  alu_op;
  logic        alu_bnegate, alu_zero, alu_overflow;
  logic [3:0]  alu_shamt;
  logic        done, illegal, zero_flag, ovf_flag;

  logic [15:0] regs [4];
  int          checks = 0;
  int          failures = 0;
  logic        exp_zero = 1'b0;
  logic        exp_ovf = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DW(16), .RA(2)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_bnegate(alu_bnegate), .alu_shamt(alu_shamt),
    .alu_rez(alu_rez), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .done(done), .illegal(illegal), .zero_flag(zero_flag), .ovf_flag(ovf_flag)
  );

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  // Environment ALU responding to the encoded controls.
  logic [15:0] bb;
  logic [16:0] sum;
  always_comb begin
    bb           = alu_bnegate ? ~alu_b : alu_b;
    sum          = {1'b0, alu_a} + {1'b0, bb} + {16'b0, alu_bnegate};
    alu_rez      = 16'h0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000: alu_rez = alu_a & alu_b;
      3'b001: alu_rez = alu_a | alu_b;
      3'b010: begin
        alu_rez      = sum[15:0];
        alu_overflow = (alu_a[15] == bb[15]) && (sum[15] != alu_a[15]);
      end
      3'b011, 3'b100: alu_rez = {15'b0, $signed(alu_a) < $signed(alu_b)};
      3'b101: alu_rez = alu_a << alu_shamt;
      3'b110: alu_rez = $signed(alu_a) >>> alu_shamt;
      default: ;
    endcase
  end
  assign alu_zero = (alu_rez == 16'h0);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Architectural result of one instruction, from signed integer arithmetic.
  task automatic ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] imm, input logic [3:0] sh,
                           output logic [15:0] res, output logic ovf);
    int sa, sb, si, s;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    si  = int'($signed(imm));
    s   = 0;
    res = 16'h0;
    ovf = 1'b0;
    case (op)
      4'd0: s = sa + sb;
      4'd1: s = sa - sb;
      4'd7: s = sa + si;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = (sa < sb) ? 16'd1 : 16'd0;
      4'd8: res = (sa < si) ? 16'd1 : 16'd0;
      4'd5: res = a << sh;
      4'd6: res = 16'($signed(a) >>> sh);
      default: ;
    endcase
    if (op == 4'd0 || op == 4'd1 || op == 4'd7) begin
      res = 16'(s);
      ovf = (s > 32767) || (s < -32768);
    end
  endtask

  function automatic logic [2:0] exp_code(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd7: return 3'b010;
      4'd2: return 3'b000;
      4'd3: return 3'b001;
      4'd4: return 3'b011;
      4'd5: return 3'b101;
      4'd6: return 3'b110;
      4'd8: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] mk_r(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt,
                                       input logic [3:0] sh);
    return {op, rs, rt, rd, sh, 2'b00};
  endfunction

  function automatic logic [15:0] mk_i(input logic [3:0] op, input logic [1:0] rt,
                                       input logic [1:0] rs, input logic [7:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("ready_wait", instr_ready, 1'b1);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after write-back.
  task automatic issue(input logic [15:0] ins);
    logic [3:0]  op;
    logic [1:0]  rs, rt, dst;
    logic        legal, imm_op;
    logic [15:0] a, b, bexp, res;
    logic        ovf;
    op     = ins[15:12];
    rs     = ins[11:10];
    rt     = ins[9:8];
    legal  = (op <= 4'd8);
    imm_op = (op == 4'd7) || (op == 4'd8);
    dst    = imm_op ? rt : ins[7:6];
    a      = regs[rs];
    b      = regs[rt];
    bexp   = imm_op ? {{8{ins[7]}}, ins[7:0]} : b;
    ref_model(op, a, b, ins[7:0], ins[5:2], res, ovf);
    wait_ready();
    instr_valid = 1'b1;
    instr       = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    chk1("dec_illegal", illegal, !legal);
    chk1("dec_ready", instr_ready, 1'b0);
    chk("dec_raddr1", 16'(rf_raddr1), 16'(rs));
    chk("dec_raddr2", 16'(rf_raddr2), 16'(rt));
    chk("dec_alu_op_idle", 16'(alu_op), 16'h0);
    if (!legal) begin
      @(negedge clk);
      chk1("ill_ready", instr_ready, 1'b1);
      chk1("ill_we", rf_we, 1'b0);
      chk1("ill_done", done, 1'b0);
      chk1("ill_zero_flag", zero_flag, exp_zero);
      chk1("ill_ovf_flag", ovf_flag, exp_ovf);
      return;
    end
    @(negedge clk);
    chk("ex_alu_op", 16'(alu_op), 16'(exp_code(op)));
    chk1("ex_bnegate", alu_bnegate, (op == 4'd1) || (op == 4'd4) || (op == 4'd8));
    chk("ex_shamt", 16'(alu_shamt), (op == 4'd5 || op == 4'd6) ? 16'(ins[5:2]) : 16'h0);
    chk("ex_alu_a", alu_a, a);
    chk("ex_alu_b", alu_b, bexp);
    chk1("ex_we", rf_we, 1'b0);
    @(negedge clk);
    chk1("wb_we", rf_we, 1'b1);
    chk1("wb_done", done, 1'b1);
    chk("wb_waddr", 16'(rf_waddr), 16'(dst));
    chk("wb_wdata", rf_wdata, res);
    if (rf_we) regs[rf_waddr] = rf_wdata;
    exp_zero = (res == 16'h0);
    exp_ovf  = ovf;
    @(negedge clk);
    chk1("post_ready", instr_ready, 1'b1);
    chk1("post_we", rf_we, 1'b0);
    chk1("post_done", done, 1'b0);
    chk1("post_zero_flag", zero_flag, exp_zero);
    chk1("post_ovf_flag", ovf_flag, exp_ovf);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) regs[i] = 16'($urandom);
    repeat (2) @(negedge clk);
    chk1("rst_ready", instr_ready, 1'b1);
    chk1("rst_we", rf_we, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk1("rst_zero_flag", zero_flag, 1'b0);
    chk1("rst_ovf_flag", ovf_flag, 1'b0);
    chk("rst_alu_a", alu_a, 16'h0);
    rst = 1'b0;

    regs[1] = 16'd5; regs[2] = 16'd3;
    issue(mk_r(4'd1, 2'd3, 2'd1, 2'd2, 4'd0));
    regs[1] = 16'h7FFF;
    issue(mk_i(4'd7, 2'd1, 2'd1, 8'h01));
    regs[1] = 16'h8000;
    issue(mk_r(4'd6, 2'd2, 2'd1, 2'd0, 4'd15));
    issue(mk_r(4'd5, 2'd2, 2'd1, 2'd0, 4'd1));
    regs[1] = 16'hFFFE;
    issue(mk_i(4'd8, 2'd2, 2'd1, 8'hFF));
    issue(16'hA000);
    issue(mk_r(4'd0, 2'd1, 2'd1, 2'd1, 4'd0));

    // Reset during EXEC of an ADD must abort without a write.
    regs[1] = 16'h1234; regs[2] = 16'h0101; regs[3] = 16'hBEEF;
    wait_ready();
    instr_valid = 1'b1;
    instr = mk_r(4'd0, 2'd3, 2'd1, 2'd2, 4'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_exec_op", 16'(alu_op), 16'h2);
    rst = 1'b1;
    #1;
    chk1("abort_ready", instr_ready, 1'b1);
    chk1("abort_we", rf_we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_zero = 1'b0;
    exp_ovf  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("abort_no_we", rf_we, 1'b0);
      chk1("abort_no_done", done, 1'b0);
      @(negedge clk);
    end
    chk1("abort_zero_flag", zero_flag, 1'b0);
    chk1("abort_ovf_flag", ovf_flag, 1'b0);
    issue(mk_r(4'd0, 2'd3, 2'd1, 2'd2, 4'd0));

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ins;
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 3)] = 16'($urandom);
      ins = 16'($urandom);
      ins[15:12] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                              : 4'($urandom_range(0, 8));
      issue(ins);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
